// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, the
// reset-time instruction, the default reset vector and decode-field positions.
package fetch_pkg;

    // Fetch FSM states; exported on the fsm_state debug port of fetch_unit.
    typedef enum logic [1:0] {
        RESET_S = 2'd0,
        FETCH   = 2'd1,
        ISSUE   = 2'd2,
        HALT    = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0 -- what Instr holds whenever nothing real has been fetched.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Default program counter after reset (word aligned).
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Bit positions of the pre-split decode fields inside an instruction word.
    localparam int OP_LSB       = 0;
    localparam int OP_MSB       = 6;
    localparam int FUNCT3_LSB   = 12;
    localparam int FUNCT3_MSB   = 14;
    localparam int FUNCT7_5_BIT = 30;

    // True when the two low address bits describe a word-aligned address.
    function automatic logic is_word_aligned(input logic [1:0] lo_bits);
        return (lo_bits == 2'b00);
    endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential PC+4 or branch target PC+ImmExt, both as
// modulo ADDR_WIDTH adds. The raw low bits of the branch target are exported
// so the fetch stage can either flag or mask a misaligned target.
module pc_next
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic [ADDR_WIDTH-1:0] ImmExt,
    input  logic                  PCSrc,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic [1:0]            target_lo,
    output logic                  target_misaligned
);

    logic [ADDR_WIDTH-1:0] branch_target;
    logic [ADDR_WIDTH-1:0] seq_target;

    // Both candidate addresses are always computed; PCSrc only steers the mux.
    always_comb begin
        branch_target     = PC + ImmExt;
        seq_target        = PC + ADDR_WIDTH'(4);
        next_pc           = PCSrc ? branch_target : seq_target;
        target_lo         = branch_target[1:0];
        target_misaligned = PCSrc && !is_word_aligned(branch_target[1:0]);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// req/ack handshake, and holds the fetched word plus its decode fields for the
// control unit until the core accepts it.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When defined, a taken branch to
// a non-word-aligned target sets the sticky Misaligned flag and parks the FSM
// in HALT (PC still shows the bad target). When undefined, target bits [1:0]
// are forced to zero, Misaligned is tied low and HALT is never entered.
//
// Handshakes:
//   imem_req/imem_ack: imem_req and imem_addr stay stable from the first FETCH
//   cycle until a cycle with imem_ack=1, which transfers imem_rdata. imem_ack is
//   ignored whenever imem_req=0, and dropping imem_req (reset) cancels a read.
//   InstrValid/Stall: an instruction is consumed in a cycle with InstrValid=1
//   and Stall=0; that is the only cycle PCSrc/ImmExt are sampled.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCSrc,
    input  logic [ADDR_WIDTH-1:0] ImmExt,
    input  logic                  Stall,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           Instr,
    output logic                  InstrValid,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [6:0]            op,
    output logic [2:0]            funct3,
    output logic                  funct7_5,
    output logic                  Misaligned,
    output fetch_state_e          fsm_state
);

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [31:0]           instr_q;

    logic                  capture;
    logic                  advance;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [ADDR_WIDTH-1:0] pc_update;
    logic [1:0]            target_lo;
    logic                  target_misaligned;

    pc_next #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_pc_next (
        .PC               (pc_q),
        .ImmExt           (ImmExt),
        .PCSrc            (PCSrc),
        .next_pc          (next_pc),
        .target_lo        (target_lo),
        .target_misaligned(target_misaligned)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned_q;

    // A bad target is kept verbatim in PC so the fault address is visible.
    assign pc_update = next_pc;

    // Sticky flag: set on a consumed, taken, misaligned branch; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else if (advance && target_misaligned) begin
            misaligned_q <= 1'b1;
        end
    end

    assign Misaligned = misaligned_q;

    // The raw low bits are only of interest to a debugger in this build.
    logic unused_target_lo;
    assign unused_target_lo = ^target_lo;
`else
    // Without the check the core can only ever fetch word addresses.
    assign pc_update = {next_pc[ADDR_WIDTH-1:2], 2'b00};
    assign Misaligned = 1'b0;

    logic unused_align;
    assign unused_align = ^{target_lo, target_misaligned};
`endif

    // Next-state and handshake outputs for the fetch FSM.
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        InstrValid = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        case (state_q)
            RESET_S: begin
                // Reached only with rst=0 here, so fetching starts next cycle.
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    capture = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                InstrValid = 1'b1;
                if (!Stall) begin
                    advance = 1'b1;
                    state_d = FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (target_misaligned) begin
                        state_d = HALT;
                    end
`endif
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RESET_S;
            end
        endcase
    end

    // FSM state register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_S;
        end else begin
            state_q <= state_d;
        end
    end

    // PC and instruction registers; an ack coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            instr_q <= NOP_INSTR;
        end else begin
            if (capture) begin
                instr_q <= imem_rdata;
            end
            if (advance) begin
                pc_q <= pc_update;
            end
        end
    end

    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign Instr     = instr_q;
    assign op        = instr_q[OP_MSB:OP_LSB];
    assign funct3    = instr_q[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7_5  = instr_q[FUNCT7_5_BIT];
    assign fsm_state = state_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle RISC-V core. Owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents the fetched instruction and its pre-split decode fields (`op`, `funct3`, `funct7_5`) to the control unit. It consumes the control unit's `PCSrc` and the immediate generator's `ImmExt` to select the next PC: branch target or sequential.

## Interface
- `ADDR_WIDTH`, 32: PC and instruction-memory address width.
- `RESET_VECTOR`, 32'h0000_0000: PC loaded on reset; must be word aligned.

- `clk` — in, 1: single clock; all state updates on its rising edge.
- `rst` — in, 1: synchronous, active-high reset.
- `PCSrc` — in, 1: branch taken, from the control unit; sampled only on the issue cycle.
- `ImmExt` — in, ADDR_WIDTH: sign-extended branch offset, relative to `PC`.
- `Stall` — in, 1: core not ready; holds the current instruction.
- `imem_req` — out, 1: read request to instruction memory.
- `imem_addr` — out, ADDR_WIDTH: word address of the request (byte address, bits [1:0] = 0).
- `imem_ack` — in, 1: read data valid this cycle.
- `imem_rdata` — in, 32: instruction word.
- `Instr` — out, 32: registered instruction.
- `InstrValid` — out, 1: `Instr`/`PC`/fields valid.
- `PC` — out, ADDR_WIDTH: address of `Instr`.
- `op` — out, 7: `Instr[6:0]`.
- `funct3` — out, 3: `Instr[14:12]`.
- `funct7_5` — out, 1: `Instr[30]`.
- `Misaligned` — out, 1: sticky misaligned-branch-target flag (see Configuration).

## Operation
- FSM states: RESET_S, FETCH, ISSUE, HALT.
- **RESET_S**
  - Entered from any state while `rst`=1.
  - `PC`=RESET_VECTOR, `Instr`=32'h0000_0013 (NOP), `imem_req`=0, `InstrValid`=0, `Misaligned`=0.
  - Transitions to FETCH on the first cycle with `rst`=0.
- **FETCH**
  - `imem_req`=1, `imem_addr`=`PC`, both held stable until `imem_ack`.
  - On `imem_ack`: capture `imem_rdata` into `Instr`, then go to ISSUE.
- **ISSUE**
  - `InstrValid`=1.
  - If `Stall`=1: hold; `Instr`, `PC`, and fields remain unchanged.
  - If `Stall`=0: sample `PCSrc`/`ImmExt`; next PC = `PCSrc` ? `PC`+`ImmExt` : `PC`+4; go to FETCH.
- **HALT**
  - Entered only via the alignment check.
  - `imem_req`=0, `InstrValid`=0; exit only by `rst`.
- Arithmetic: ADDR_WIDTH-bit modulo add. Wrap from 32'hFFFF_FFFC + 4 gives 0, with no flag.
- `imem_ack` while `imem_req`=0 (RESET_S, ISSUE, HALT) is ignored. Instruction memory treats a `imem_req` drop as cancelling any outstanding read.
- Field outputs are pure slices of the `Instr` register. They are valid only with `InstrValid`.

## Timing
- Request to issue: `imem_req` rises in cycle N. If `imem_ack` arrives in cycle N+k (k≥0), `InstrValid`=1 from cycle N+k+1.
- Zero-wait memory gives peak throughput of one instruction per 2 cycles.
- Issue to next request: `PCSrc` is sampled in the issue cycle I. The new `PC` and `imem_req` appear in I+1.
- Reset: `rst` asserted in cycle R forces RESET_S values from R+1. `imem_req` is first asserted in the cycle after `rst` deasserts.
- Reset mid-FETCH: the request is dropped. An ack in the same edge as `rst` is discarded.
- Simultaneous `Stall`=1 and `PCSrc`=1: `PCSrc` is ignored until the cycle `Stall` drops. The control unit must hold `PCSrc` valid until then.

## Configuration
- `FETCH_ALIGN_CHECK_EN`
  - **Defined:** on an issue cycle with `PCSrc`=1 and (`PC`+`ImmExt`)[1:0]≠0:
    - `Misaligned` is set to 1 and held until reset.
    - FSM goes to HALT instead of FETCH.
    - `PC` still updates to the unaligned target, for debug.
  - **Undefined:**
    - Target bits [1:0] are forced to 0.
    - `Misaligned` is tied to 0.
    - HALT is unreachable.

## Structure
- Package `fetch_pkg`:
  - FSM state enum.
  - `NOP_INSTR` = 32'h0000_0013.
  - Default `RESET_VECTOR`.
  - Field bit positions for `op`/`funct3`/`funct7_5`.
- Sub-module `pc_next`: combinational next-PC adder/mux (inputs `PC`, `ImmExt`, `PCSrc`). Exports the target alignment bits for the optional check.

## Test plan
- Reset then zero-wait memory returning 32'h0000_0013 → `imem_addr` sequence 0, 4, 8. `InstrValid` pulses every 2nd cycle. `op`=7'h13.
- Memory with ack delayed 3 cycles → `imem_req` and `imem_addr` stable for 4 cycles. `Instr` captures the ack-cycle data only.
- Issue at `PC`=32'h10, `PCSrc`=1, `ImmExt`=32'hFFFF_FFF8 → next `imem_addr`=32'h08. With `PCSrc`=0 → 32'h14.
- `Stall`=1 for 5 cycles while `PCSrc` toggles → `PC` and `Instr` frozen. Branch is decided by the `PCSrc` value in the first `Stall`=0 cycle.
- `rst` asserted while `imem_req`=1 and ack is pending → next cycle `PC`=RESET_VECTOR, `InstrValid`=0. A stray ack is ignored.
- With `FETCH_ALIGN_CHECK_EN`, `ImmExt`=2 taken → `Misaligned`=1, `imem_req` stays 0 until reset. Without the macro → `imem_addr`=`PC`.
